// File: rtl/alu_seq_core.sv
// Registered, handshaked ALU: single-cycle arithmetic/logic ops plus an iterative restoring divider.
// Results and flags are held in output registers until the consumer takes them.
module alu_seq_core #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SHIFT_AMT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OpAdd  = 4'h0, OpSub  = 4'h1, OpMul  = 4'h2, OpDiv  = 4'h3,
    OpShl  = 4'h4, OpShr  = 4'h5, OpRol  = 4'h6, OpRor  = 4'h7,
    OpAnd  = 4'h8, OpOr   = 4'h9, OpXor  = 4'hA, OpNor  = 4'hB,
    OpNand = 4'hC, OpXnor = 4'hD, OpGt   = 4'hE, OpEq   = 4'hF
  } op_e;

  typedef enum logic [1:0] {StIdle, StExec, StDiv, StOut} state_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  result_hi_q, result_hi_d;
  logic              carry_q, carry_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;
  logic              div_zero_q, div_zero_d;

  logic              accept;
  logic              new_is_div;
  logic [WIDTH:0]    sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]    div_shift, div_trial;
  logic              div_bit;
  logic [WIDTH-1:0]  ex_res, ex_hi;
  logic              ex_c, ex_ov, ex_dz;

  assign in_ready   = (state_q == StIdle) | ((state_q == StOut) & out_ready);
  assign accept     = in_valid & in_ready;
  // Divide by zero skips the iteration and is formatted directly in EXEC.
  assign new_is_div = (opcode == OpDiv) & (op_b != '0);

  assign out_valid  = (state_q == StOut);
  assign busy       = (state_q == StDiv);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;
  assign div_zero   = div_zero_q;

  // Restoring divide step: a_q shifts the dividend out MSB-first and the quotient in LSB-first.
  always_comb begin
    div_shift = {rem_q, a_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_bit   = ~div_trial[WIDTH];
  end

  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    ex_res = '0;
    ex_hi  = '0;
    ex_c   = 1'b0;
    ex_ov  = 1'b0;
    ex_dz  = 1'b0;
    unique case (op_q)
      OpAdd: begin
        ex_res = sum[WIDTH-1:0];
        ex_c   = sum[WIDTH];
        ex_ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        ex_res = diff[WIDTH-1:0];
        ex_c   = diff[WIDTH];
        ex_ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpMul: begin
        ex_res = prod[WIDTH-1:0];
        ex_hi  = prod[2*WIDTH-1:WIDTH];
      end
      OpDiv: begin
        if (b_q == '0) begin
          ex_res = '1;
          ex_hi  = a_q;
          ex_dz  = 1'b1;
        end else begin
          ex_res = a_q;
          ex_hi  = rem_q;
        end
      end
      OpShl: begin
        ex_res = a_q << SHIFT_AMT;
        ex_c   = a_q[WIDTH-SHIFT_AMT];
      end
      OpShr: begin
        ex_res = a_q >> SHIFT_AMT;
        ex_c   = a_q[SHIFT_AMT-1];
      end
      OpRol: begin
        ex_res = (a_q << SHIFT_AMT) | (a_q >> (WIDTH - SHIFT_AMT));
        ex_c   = a_q[WIDTH-SHIFT_AMT];
      end
      OpRor: begin
        ex_res = (a_q >> SHIFT_AMT) | (a_q << (WIDTH - SHIFT_AMT));
        ex_c   = a_q[SHIFT_AMT-1];
      end
      OpAnd:  ex_res = a_q & b_q;
      OpOr:   ex_res = a_q | b_q;
      OpXor:  ex_res = a_q ^ b_q;
      OpNor:  ex_res = ~(a_q | b_q);
      OpNand: ex_res = ~(a_q & b_q);
      OpXnor: ex_res = ~(a_q ^ b_q);
      OpGt:   ex_res = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
      OpEq:   ex_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      default: ex_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;

    if (accept) begin
      op_d    = op_e'(opcode);
      a_d     = op_a;
      b_d     = op_b;
      rem_d   = '0;
      cnt_d   = CntW'(WIDTH - 1);
      state_d = new_is_div ? StDiv : StExec;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StDiv: begin
          a_d   = {a_q[WIDTH-2:0], div_bit};
          rem_d = div_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          cnt_d = cnt_q - CntW'(1);
          // Final iteration hands off to EXEC, which formats quotient/remainder.
          if (cnt_q == '0) state_d = StExec;
        end
        StExec: state_d = StOut;
        StOut: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_q == StExec) begin
      result_d    = ex_res;
      result_hi_d = ex_hi;
      carry_d     = ex_c;
      overflow_d  = ex_ov;
      zero_d      = (ex_res == '0);
      div_zero_d  = ex_dz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpAdd;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed scenario tasks plus a randomised scoreboard run at WIDTH=16.
module tb_alu_seq_core;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         c;
    logic         ov;
    logic         z;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, result_hi;
  logic         carry, overflow, zero, div_zero, busy;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  bit   rand_rdy = 1'b0;

  alu_seq_core #(.WIDTH(W), .SHIFT_AMT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .carry(carry), .overflow(overflow), .zero(zero),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned ua, ub, w;
    int          sa, sb_, s;
    e  = '0;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb_ = $signed(b);
    case (op)
      4'h0: begin w = ua + ub; e.r = w[W-1:0]; e.c = w[W]; s = sa + sb_;
                  e.ov = (s > 32767) || (s < -32768); end
      4'h1: begin e.r = a - b; e.c = (ua < ub); s = sa - sb_;
                  e.ov = (s > 32767) || (s < -32768); end
      4'h2: begin w = ua * ub; e.r = w[15:0]; e.hi = w[31:16]; end
      4'h3: if (ub == 0) begin e.r = 16'hFFFF; e.hi = a; e.dz = 1'b1; end
            else begin w = ua / ub; e.r = w[15:0]; w = ua % ub; e.hi = w[15:0]; end
      4'h4: begin e.r = {a[14:0], 1'b0}; e.c = a[15]; end
      4'h5: begin e.r = {1'b0, a[15:1]}; e.c = a[0]; end
      4'h6: begin e.r = {a[14:0], a[15]}; e.c = a[15]; end
      4'h7: begin e.r = {a[0], a[15:1]}; e.c = a[0]; end
      4'h8: e.r = a & b;
      4'h9: e.r = a | b;
      4'hA: e.r = a ^ b;
      4'hB: e.r = ~(a | b);
      4'hC: e.r = ~(a & b);
      4'hD: e.r = ~(a ^ b);
      4'hE: e.r = (ua > ub) ? 16'd1 : 16'd0;
      default: e.r = (ua == ub) ? 16'd1 : 16'd0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: every completed handshake is checked against the oldest pushed expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got result=%h with no op outstanding", result);
      end else begin
        e = sb.pop_front();
        if ({result, result_hi, carry, overflow, zero, div_zero} !== e) begin
          bad++;
          $display("FAIL sb_compare: got r=%h hi=%h c=%b ov=%b z=%b dz=%b want r=%h hi=%h c=%b ov=%b z=%b dz=%b",
                   result, result_hi, carry, overflow, zero, div_zero,
                   e.r, e.hi, e.c, e.ov, e.z, e.dz);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op; op_a = a; op_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1; returns at the negedge where out_valid is seen.
  task automatic wait_out(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) return;
      if (busy) busy_n++;
      lat++;
      if (lat > 200) begin
        total++; bad++;
        $display("FAIL out_timeout: out_valid=%b after %0d edges, want 1", out_valid, lat);
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if ({result, result_hi, carry, overflow, zero, div_zero} !== '0) begin
      bad++; $display("FAIL reset_outputs: got r=%h hi=%h flags=%b%b%b%b want all 0",
                      result, result_hi, carry, overflow, zero, div_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_addsub;
    int lat, bn;
    out_ready = 1'b1;
    send(4'h0, 16'hFFFF, 16'h0001); wait_out(lat, bn);
    total++;
    if ({result, carry, zero, overflow} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_wrap: got r=%h c=%b z=%b ov=%b want r=0000 c=1 z=1 ov=0",
                      result, carry, zero, overflow);
    end
    total++; if (lat != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
    send(4'h0, 16'h7FFF, 16'h0001); wait_out(lat, bn);
    total++;
    if ({result, overflow, carry} !== {16'h8000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_ovf: got r=%h ov=%b c=%b want r=8000 ov=1 c=0", result, overflow, carry);
    end
    send(4'h1, 16'h0003, 16'h0005); wait_out(lat, bn);
    total++;
    if ({result, carry, overflow} !== {16'hFFFE, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_borrow: got r=%h c=%b ov=%b want r=fffe c=1 ov=0", result, carry, overflow);
    end
  endtask

  task automatic test_mul;
    int lat, bn;
    out_ready = 1'b1;
    send(4'h2, 16'hFFFF, 16'hFFFF); wait_out(lat, bn);
    total++;
    if ({result_hi, result} !== 32'hFFFE_0001) begin
      bad++; $display("FAIL mul_full: got hi=%h r=%h want hi=fffe r=0001", result_hi, result);
    end
    total++; if (lat != 2) begin bad++; $display("FAIL mul_latency: got %0d want 2", lat); end
  endtask

  task automatic test_div;
    int lat, bn;
    out_ready = 1'b1;
    send(4'h3, 16'd1000, 16'd7); wait_out(lat, bn);
    total++;
    if ({result, result_hi, div_zero} !== {16'd142, 16'd6, 1'b0}) begin
      bad++; $display("FAIL div_1000_7: got q=%0d r=%0d dz=%b want q=142 r=6 dz=0", result, result_hi, div_zero);
    end
    total++; if (lat != 18) begin bad++; $display("FAIL div_latency: got %0d want 18", lat); end
    total++; if (bn != 16) begin bad++; $display("FAIL div_busy: got %0d cycles want 16", bn); end
    send(4'h3, 16'd5, 16'd0); wait_out(lat, bn);
    total++;
    if ({result, result_hi, div_zero, carry, overflow} !== {16'hFFFF, 16'd5, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL div_by_zero: got r=%h hi=%h dz=%b c=%b ov=%b want r=ffff hi=0005 dz=1 c=0 ov=0",
                      result, result_hi, div_zero, carry, overflow);
    end
    total++; if (lat != 2) begin bad++; $display("FAIL div0_latency: got %0d want 2", lat); end
  endtask

  task automatic test_reset_mid_div;
    int stale = 0;
    out_ready = 1'b1;
    send(4'h3, 16'd1000, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({out_valid, in_ready, busy, result} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL reset_mid_div: got ov=%b ir=%b busy=%b r=%h want ov=0 ir=1 busy=0 r=0000",
                      out_valid, in_ready, busy, result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL reset_stale: got %0d active cycles want 0", stale); end
  endtask

  task automatic test_backpressure;
    int lat, bn;
    int hold_bad = 0;
    out_ready = 1'b0;
    send(4'hA, 16'hA5A5, 16'h5A5A); wait_out(lat, bn);
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 4'h0; op_a = 16'd1; op_b = 16'd2;
    repeat (10) begin
      @(negedge clk);
      if (result !== 16'hFFFF || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    sb.push_back(model(4'h0, 16'd1, 16'd2));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, bn);
    total++;
    if (result !== 16'd3 || lat != 2) begin
      bad++; $display("FAIL bp_queued_op: got r=%h lat=%0d want r=0003 lat=2", result, lat);
    end
  endtask

  task automatic test_shift;
    int lat, bn;
    out_ready = 1'b1;
    send(4'h6, 16'h8001, 16'h0); wait_out(lat, bn);
    total++;
    if ({result, carry} !== {16'h0003, 1'b1}) begin
      bad++; $display("FAIL rol: got r=%h c=%b want r=0003 c=1", result, carry);
    end
    send(4'h5, 16'h0001, 16'h0); wait_out(lat, bn);
    total++;
    if ({result, carry, zero} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL shr: got r=%h c=%b z=%b want r=0000 c=1 z=1", result, carry, zero);
    end
    send(4'hE, 16'd5, 16'd3); wait_out(lat, bn);
    total++; if (result !== 16'h0001) begin bad++; $display("FAIL gt: got %h want 0001", result); end
    send(4'hF, 16'd4, 16'd5); wait_out(lat, bn);
    total++;
    if ({result, zero} !== {16'h0000, 1'b1}) begin
      bad++; $display("FAIL eq: got r=%h z=%b want r=0000 z=1", result, zero);
    end
  endtask

  task automatic test_back_to_back;
    time t0, t1;
    int  lat, bn;
    out_ready = 1'b1;
    send(4'hA, 16'h1234, 16'h00FF);
    t0 = $time;
    send(4'h8, 16'hF0F0, 16'h3C3C);
    send(4'h0, 16'h1111, 16'h2222);
    send(4'h1, 16'h0100, 16'h0001);
    t1 = $time;
    total++;
    if (t1 - t0 != 60) begin bad++; $display("FAIL b2b_rate: got %0t between first/last accept want 60", t1 - t0); end
    wait_out(lat, bn);
  endtask

  task automatic test_random;
    int n = 0;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = '1;
        2: begin a = 16'h8000; b = 16'h7FFF; end
        3: b = 16'($urandom_range(1, 9));
        default: ;
      endcase
      send(op, a, b);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d outstanding want 0", sb.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_addsub;
    test_mul;
    test_div;
    test_reset_mid_div;
    test_backpressure;
    test_shift;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
